// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the fetch PC, talks to a variable-latency
// instruction memory and feeds the decoder through an IF/ID register.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] PC_STEP  = 32'd4,
  parameter logic [31:0] NOP_WORD = 32'hE1A0_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        imem_valid,
  output logic [31:0] instr_out,
  output logic        instr_valid,
  output logic [31:0] pc_out,
  output logic [31:0] pc_plus8
);

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_WAIT = 2'd1,
    ST_FULL = 2'd2
  } st_e;

  st_e         state_q, state_d;
  logic [31:0] fpc_q, fpc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pc_q, pc_d;
  logic        vld_q, vld_d;
  logic        drop_q, drop_d;
  logic [31:0] bi_q, bi_d;
  logic [31:0] bp_q, bp_d;
  logic        req_q, req_d;
  logic [31:0] addr_q, addr_d;

  logic        unused_rpc;
  assign unused_rpc = ^redirect_pc[1:0];

  always_comb begin
    state_d = state_q;
    fpc_d   = fpc_q;
    instr_d = instr_q;
    pc_d    = pc_q;
    vld_d   = vld_q;
    drop_d  = drop_q;
    bi_d    = bi_q;
    bp_d    = bp_q;
    if (redirect) begin
      vld_d   = 1'b0;
      instr_d = NOP_WORD;
      fpc_d   = {redirect_pc[31:2], 2'b00};
      state_d = ST_WAIT;
      drop_d  = (state_q == ST_WAIT) && !imem_valid;
    end else begin
      unique case (state_q)
        ST_BOOT: state_d = ST_WAIT;
        ST_WAIT: begin
          if (imem_valid) begin
            if (drop_q) begin
              drop_d = 1'b0;
            end else if (!vld_q || !stall) begin
              instr_d = imem_rdata;
              pc_d    = fpc_q;
              vld_d   = 1'b1;
              fpc_d   = fpc_q + PC_STEP;
            end else begin
              bi_d    = imem_rdata;
              bp_d    = fpc_q;
              state_d = ST_FULL;
            end
          end else if (!stall && vld_q) begin
            vld_d   = 1'b0;
            instr_d = NOP_WORD;
          end
        end
        ST_FULL: begin
          if (!stall) begin
            instr_d = bi_q;
            pc_d    = bp_q;
            vld_d   = 1'b1;
            fpc_d   = fpc_q + PC_STEP;
            state_d = ST_WAIT;
          end
        end
        default: state_d = ST_BOOT;
      endcase
    end
    // An in-flight request keeps its address until its response is dropped
    req_d  = (state_d == ST_WAIT);
    addr_d = drop_d ? addr_q : fpc_d;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= ST_BOOT;
      fpc_q   <= RESET_PC;
      instr_q <= NOP_WORD;
      pc_q    <= 32'h0;
      vld_q   <= 1'b0;
      drop_q  <= 1'b0;
      bi_q    <= 32'h0;
      bp_q    <= 32'h0;
      req_q   <= 1'b0;
      addr_q  <= RESET_PC;
    end else begin
      state_q <= state_d;
      fpc_q   <= fpc_d;
      instr_q <= instr_d;
      pc_q    <= pc_d;
      vld_q   <= vld_d;
      drop_q  <= drop_d;
      bi_q    <= bi_d;
      bp_q    <= bp_d;
      req_q   <= req_d;
      addr_q  <= addr_d;
    end
  end

  assign imem_req    = req_q;
  assign imem_addr   = addr_q;
  assign instr_out   = instr_q;
  assign instr_valid = vld_q;
  assign pc_out      = pc_q;
  assign pc_plus8    = pc_q + 32'd8;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a latency-programmable memory model.
module tb_fetch_unit;

  localparam logic [31:0] NOP = 32'hE1A0_0000;
  localparam logic [31:0] KEY = 32'h5A5A_0000;

  logic        clk;
  logic        rst;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        imem_valid;
  logic [31:0] instr_out;
  logic        instr_valid;
  logic [31:0] pc_out;
  logic [31:0] pc_plus8;

  int tests;
  int fails;
  int lat;
  int cnt;
  logic force_v;

  fetch_unit dut (
    .clk(clk),
    .rst(rst),
    .stall(stall),
    .redirect(redirect),
    .redirect_pc(redirect_pc),
    .imem_req(imem_req),
    .imem_addr(imem_addr),
    .imem_rdata(imem_rdata),
    .imem_valid(imem_valid),
    .instr_out(instr_out),
    .instr_valid(instr_valid),
    .pc_out(pc_out),
    .pc_plus8(pc_plus8)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Memory answers once a request has been up for lat cycles
  assign imem_valid = force_v | (imem_req && (cnt == lat - 1));
  assign imem_rdata = imem_addr ^ KEY;

  always @(posedge clk) begin
    if (!imem_req || imem_valid) cnt <= 0;
    else cnt <= cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    tests = 0;
    fails = 0;
    lat = 1;
    cnt = 0;
    force_v = 1'b0;
    rst = 1'b0;
    stall = 1'b0;
    redirect = 1'b0;
    redirect_pc = 32'h0;
    step();
    step();
    chk("rst_instr", instr_out, NOP);
    chk("rst_valid", {31'b0, instr_valid}, 32'd0);
    chk("rst_pc", pc_out, 32'h0);
    chk("rst_req", {31'b0, imem_req}, 32'd0);
    rst = 1'b1;

    step();
    chk("boot_req", {31'b0, imem_req}, 32'd1);
    chk("boot_addr", imem_addr, 32'h0);
    chk("boot_valid", {31'b0, instr_valid}, 32'd0);
    step();
    chk("seq0_valid", {31'b0, instr_valid}, 32'd1);
    chk("seq0_pc", pc_out, 32'h0);
    chk("seq0_instr", instr_out, 32'h0 ^ KEY);
    chk("seq0_p8", pc_plus8, 32'h8);
    chk("seq0_addr", imem_addr, 32'h4);
    step();
    chk("seq1_pc", pc_out, 32'h4);
    chk("seq1_p8", pc_plus8, 32'hC);
    chk("seq1_addr", imem_addr, 32'h8);

    stall = 1'b1;
    step();
    chk("full_req", {31'b0, imem_req}, 32'd0);
    chk("full_pc", pc_out, 32'h4);
    step();
    step();
    chk("hold_pc", pc_out, 32'h4);
    chk("hold_instr", instr_out, 32'h4 ^ KEY);
    chk("hold_valid", {31'b0, instr_valid}, 32'd1);
    chk("hold_req", {31'b0, imem_req}, 32'd0);
    stall = 1'b0;
    step();
    chk("unbuf_pc", pc_out, 32'h8);
    chk("unbuf_instr", instr_out, 32'h8 ^ KEY);
    chk("unbuf_addr", imem_addr, 32'hC);
    step();
    chk("resume_pc", pc_out, 32'hC);
    chk("resume_p8", pc_plus8, 32'h14);
    chk("resume_addr", imem_addr, 32'h10);

    lat = 3;
    stall = 1'b1;
    step();
    chk("stallw_pc", pc_out, 32'hC);
    chk("stallw_valid", {31'b0, instr_valid}, 32'd1);
    redirect = 1'b1;
    redirect_pc = 32'h103;
    stall = 1'b0;
    step();
    chk("rd_valid", {31'b0, instr_valid}, 32'd0);
    chk("rd_instr", instr_out, NOP);
    chk("rd_addr_held", imem_addr, 32'h10);
    chk("rd_req", {31'b0, imem_req}, 32'd1);
    redirect = 1'b0;
    step();
    chk("drop_valid", {31'b0, instr_valid}, 32'd0);
    chk("drop_addr", imem_addr, 32'h100);
    lat = 1;
    step();
    chk("tgt_pc", pc_out, 32'h100);
    chk("tgt_instr", instr_out, 32'h100 ^ KEY);
    chk("tgt_valid", {31'b0, instr_valid}, 32'd1);

    stall = 1'b1;
    redirect = 1'b1;
    redirect_pc = 32'h200;
    step();
    chk("rdv_valid", {31'b0, instr_valid}, 32'd0);
    chk("rdv_instr", instr_out, NOP);
    chk("rdv_addr", imem_addr, 32'h200);
    chk("rdv_req", {31'b0, imem_req}, 32'd1);
    redirect = 1'b0;
    step();
    chk("rdv_pc", pc_out, 32'h200);
    chk("rdv_instr2", instr_out, 32'h200 ^ KEY);
    stall = 1'b0;
    step();
    chk("rdv_next_pc", pc_out, 32'h204);

    redirect = 1'b1;
    redirect_pc = 32'hFFFF_FFFF;
    step();
    chk("wrap_addr", imem_addr, 32'hFFFF_FFFC);
    redirect = 1'b0;
    step();
    chk("wrap_pc", pc_out, 32'hFFFF_FFFC);
    chk("wrap_p8", pc_plus8, 32'h4);
    chk("wrap_next", imem_addr, 32'h0);
    step();
    chk("wrap_pc0", pc_out, 32'h0);
    chk("wrap_p8b", pc_plus8, 32'h8);

    rst = 1'b0;
    lat = 3;
    step();
    chk("mrst_instr", instr_out, NOP);
    chk("mrst_valid", {31'b0, instr_valid}, 32'd0);
    chk("mrst_pc", pc_out, 32'h0);
    chk("mrst_req", {31'b0, imem_req}, 32'd0);
    rst = 1'b1;
    force_v = 1'b1;
    step();
    chk("late_valid", {31'b0, instr_valid}, 32'd0);
    chk("late_pc", pc_out, 32'h0);
    chk("late_req", {31'b0, imem_req}, 32'd1);
    chk("late_addr", imem_addr, 32'h0);
    force_v = 1'b0;
    lat = 1;
    step();
    chk("restart_valid", {31'b0, instr_valid}, 32'd1);
    chk("restart_pc", pc_out, 32'h0);
    chk("restart_instr", instr_out, 32'h0 ^ KEY);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
